serial_add: RTL and testbench
=============================

# serial_add

Bit-serial WIDTH-bit adder with start/done handshake. It computes f = x + y + cin, one bit per clock, LSB first, and reports unsigned carry-out and signed overflow. It is the addition counterpart to the gate-level subtractor in the ALU datapath: it trades 32 full adders for one full-adder slice plus shift registers. Subtraction is obtained by driving y with ~y and setting cin = 1.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 2).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on the rising edge and accepted only when the block is not in RUN.
- x  input  WIDTH  operand A; captured on the accepting edge.
- y  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; results are valid from this cycle onward.
- f  output  WIDTH  sum; registered and held until the next completion.
- cout  output  1  carry out of bit WIDTH-1; held with f.
- overflow  output  1  signed overflow = carry into MSB XOR cout; held with f.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE: if start, load the shift registers a←x, b←y, load carry←cin, set count←0, and go to RUN. Otherwise stay.
- RUN, each cycle:
  - s = a[0]^b[0]^carry.
  - carry ← majority(a[0], b[0], carry).
  - acc ← {s, acc[WIDTH-1:1]}.
  - a and b shift right by 1.
  - count ← count+1.
  - On the count = WIDTH-1 cycle, also save carry_in_msb ← the current carry.
  - After processing bit WIDTH-1, go to DONE.
- Transition to DONE loads the output registers:
  - f ← final acc, including the MSB bit computed in that cycle.
  - cout ← the final carry.
  - overflow ← carry_in_msb ^ final carry.
- DONE: done = 1 for exactly this cycle.
  - If start is asserted here, load the new operands and go to RUN (back-to-back, no IDLE cycle).
  - Otherwise go to IDLE.
- start while in RUN is ignored and has no effect on the operation in progress. It is not queued.
- x, y, cin may change freely after the accepting edge.
- f, cout, overflow change only on entry to DONE. During a later RUN they keep the previous result.
- The count register is $clog2(WIDTH) bits wide and never wraps past WIDTH-1 within an operation.
- Arithmetic is modulo 2^WIDTH. cout is the unsigned carry. overflow is the two's-complement overflow.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE; busy = 0, done = 0, f = 0, cout = 0, overflow = 0; internal registers cleared.
- Release of rst_n takes effect at the next clock edge. No partial result is ever reported.
- Reset asserted mid-RUN aborts the operation immediately: no done pulse, outputs go to 0.
- Latency: start accepted at edge E0.
  - busy is high from after E0 through edge E_WIDTH: exactly WIDTH cycles.
  - done is high for one cycle after E_WIDTH, together with the new f/cout/overflow.
  - Total: WIDTH+1 cycles from start sampling to the done cycle.
- Throughput: one result per WIDTH+1 cycles when start is held high continuously.
- busy and done are never high in the same cycle. Both are registered (state decode of registered state).

## Test plan
- x=9, y=19, cin=0, start pulse → busy high for 32 cycles, then done pulse with f=28, cout=0, overflow=0; done high in cycle 33 after start.
- x=0xFFFFFFFF, y=0x00000001, cin=0 → f=0x00000000, cout=1, overflow=0. Then x=0x7FFFFFFF, y=1 → f=0x80000000, cout=0, overflow=1.
- Subtraction use: x=9, y=~19 (0xFFFFFFEC), cin=1 → f=0xFFFFFFF6 (−10), cout=0, overflow=0. Also x=0x80000000, y=~1, cin=1 → f=0x7FFFFFFF, overflow=1, cout=1.
- Start pulsed again mid-RUN with different operands → ignored: first result unchanged, single done pulse, busy length still 32. Start held high → back-to-back results, done every 33 cycles, no idle gap.
- rst_n pulled low at cycle 10 of RUN → all outputs 0 asynchronously, no done. After release, new start x=3, y=4 → f=7 with normal latency.
- Previous result f=28 remains stable on f throughout a subsequent RUN until that run's done cycle updates it.

Source files
------------

// File: rtl/serial_add_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The requester (master) drives start and the operands; the adder (slave)
// returns busy/done and the held result.
interface serial_add_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] f;
  logic             cout;
  logic             overflow;

  modport master (
    output start, x, y, cin,
    input  busy, done, f, cout, overflow
  );

  modport slave (
    input  start, x, y, cin,
    output busy, done, f, cout, overflow
  );
endinterface

// File: rtl/serial_add.sv
// Bit-serial WIDTH-bit adder: f = x + y + cin, one bit per clock, LSB first.
// A single full-adder slice walks the operand shift registers; the sum bits
// are shifted into an accumulator from the top so that after WIDTH cycles the
// accumulator holds the sum in natural bit order. Results (f, cout, overflow)
// are held in their own registers and only change on entry to DONE.
module serial_add #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_add_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Carry out of a full-adder slice.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sum_s;
  logic             carry_nxt_s;

  // Next-state, datapath and result-register update logic.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    count_d     = count_q;
    f_d         = f_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    sum_s       = a_q[0] ^ b_q[0] ^ carry_q;
    carry_nxt_s = maj3(a_q[0], b_q[0], carry_q);

    case (state_q)
      // IDLE and DONE both accept a new request; DONE goes straight back
      // to RUN so held-high start gives back-to-back results.
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_d     = bus.x;
          b_d     = bus.y;
          carry_d = bus.cin;
          acc_d   = '0;
          count_d = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        acc_d   = {sum_s, acc_q[WIDTH-1:1]};
        carry_d = carry_nxt_s;
        if (count_q == LAST_CNT) begin
          // On the MSB cycle carry_q is the carry into the MSB, so the
          // signed overflow is formed here directly from it and the
          // carry out of the MSB slice.
          f_d     = {sum_s, acc_q[WIDTH-1:1]};
          cout_d  = carry_nxt_s;
          ovf_d   = carry_q ^ carry_nxt_s;
          state_d = S_DONE;
        end else begin
          count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and output registers; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      f_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      count_q <= count_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.f        = f_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_add.sv
// Directed bench for serial_add: a vector table of hand-computed sums plus
// sequences for mid-run start, back-to-back operation, result hold and reset.
module tb_serial_add;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_add_if #(.WIDTH(W)) bus ();

  serial_add #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic [31:0] f;
    logic        cout;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Issue one operation and watch it to completion (bounded).
  // busy_n counts post-edge samples with busy high, lat is the edge index
  // (E0 = 0) after which done was seen, both counts busy&done overlaps.
  task automatic run_op(input logic [31:0] xv, input logic [31:0] yv, input logic cv,
                        output int busy_n, output int lat, output int both);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = xv;
    bus.y     = yv;
    bus.cin   = cv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x     = $urandom;
    bus.y     = $urandom;
    bus.cin   = 1'b1;
    busy_n = bus.busy ? 1 : 0;
    both   = 0;
    lat    = -1;
    for (int n = 1; n <= 100 && lat < 0; n++) begin
      @(posedge clk);
      #1;
      if (bus.busy) busy_n++;
      if (bus.busy && bus.done) both++;
      if (bus.done) lat = n;
    end
  endtask

  vec_t vecs[10];

  initial begin
    int busy_n, lat, both, dones, stable_bad;
    int dpos[3];
    int nd;
    logic [31:0] exp_b2b[3];

    total = 0;
    bad   = 0;

    vecs[0] = '{32'd9,          32'd19,         1'b0, 32'd28,         1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF,   32'h00000001,   1'b0, 32'h00000000,   1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF,   32'h00000001,   1'b0, 32'h80000000,   1'b0, 1'b1};
    vecs[3] = '{32'd9,          32'hFFFFFFEC,   1'b1, 32'hFFFFFFF6,   1'b0, 1'b0};
    vecs[4] = '{32'h80000000,   32'hFFFFFFFE,   1'b1, 32'h7FFFFFFF,   1'b1, 1'b1};
    vecs[5] = '{32'd3,          32'd4,          1'b0, 32'd7,          1'b0, 1'b0};
    vecs[6] = '{32'd0,          32'd0,          1'b1, 32'd1,          1'b0, 1'b0};
    vecs[7] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 32'hFFFFFFFF,   1'b1, 1'b0};
    vecs[8] = '{32'h40000000,   32'h40000000,   1'b0, 32'h80000000,   1'b0, 1'b1};
    vecs[9] = '{32'h12345678,   32'h9ABCDEF0,   1'b0, 32'hACF13568,   1'b0, 1'b0};

    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    bus.cin   = 1'b0;
    rst_n     = 1'b0;
    #12;
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_f", {32'd0, bus.f}, 64'd0);
    chk("rst_cout", {63'd0, bus.cout}, 64'd0);
    chk("rst_ovf", {63'd0, bus.overflow}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", {63'd0, bus.busy}, 64'd0);

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].cin, busy_n, lat, both);
      chk($sformatf("v%0d_f", i), {32'd0, bus.f}, {32'd0, vecs[i].f});
      chk($sformatf("v%0d_cout", i), {63'd0, bus.cout}, {63'd0, vecs[i].cout});
      chk($sformatf("v%0d_ovf", i), {63'd0, bus.overflow}, {63'd0, vecs[i].ovf});
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(W));
      chk($sformatf("v%0d_busylen", i), 64'(busy_n), 64'(W));
      chk($sformatf("v%0d_overlap", i), 64'(both), 64'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), {63'd0, bus.done}, 64'd0);
    end

    // Start pulsed mid-run with other operands: ignored, not queued.
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = 32'd9;
    bus.y     = 32'd19;
    bus.cin   = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    busy_n = bus.busy ? 1 : 0;
    dones  = 0;
    lat    = -1;
    for (int n = 1; n <= 70; n++) begin
      @(posedge clk);
      #1;
      if (n == 5) begin
        bus.start = 1'b1;
        bus.x     = 32'd1;
        bus.y     = 32'd1;
      end
      if (n == 6) bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        dones++;
        if (lat < 0) lat = n;
      end
    end
    chk("midstart_f", {32'd0, bus.f}, 64'd28);
    chk("midstart_dones", 64'(dones), 64'd1);
    chk("midstart_busylen", 64'(busy_n), 64'(W));
    chk("midstart_lat", 64'(lat), 64'(W));

    // f=28 must stay put during the next run until its done cycle.
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = 32'hFFFFFFFF;
    bus.y     = 32'h00000001;
    bus.cin   = 1'b0;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    stable_bad = 0;
    lat        = -1;
    for (int n = 1; n <= 100 && lat < 0; n++) begin
      if (bus.f !== 32'd28 || bus.cout !== 1'b0) stable_bad++;
      @(posedge clk);
      #1;
      if (bus.done) lat = n;
    end
    chk("hold_stable", 64'(stable_bad), 64'd0);
    chk("hold_new_f", {32'd0, bus.f}, 64'd0);
    chk("hold_new_cout", {63'd0, bus.cout}, 64'd1);

    // Start held high: results back to back, done every W+1 cycles.
    exp_b2b[0] = 32'd11;
    exp_b2b[1] = 32'd123;
    exp_b2b[2] = 32'd15;
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = 32'd5;
    bus.y     = 32'd6;
    bus.cin   = 1'b0;
    @(posedge clk);
    #1;
    bus.x = 32'hDEAD0000;
    nd    = 0;
    both  = 0;
    for (int k = 0; k < 3; k++) dpos[k] = -1;
    for (int n = 1; n <= 150 && nd < 3; n++) begin
      @(posedge clk);
      #1;
      if (bus.busy && bus.done) both++;
      if (bus.done) begin
        dpos[nd] = n;
        chk($sformatf("b2b%0d_f", nd), {32'd0, bus.f}, {32'd0, exp_b2b[nd]});
        if (nd == 0) begin
          bus.x = 32'd100;
          bus.y = 32'd23;
        end else if (nd == 1) begin
          bus.x = 32'd7;
          bus.y = 32'd8;
        end else begin
          bus.start = 1'b0;
        end
        nd++;
      end
    end
    bus.start = 1'b0;
    chk("b2b_count", 64'(nd), 64'd3);
    chk("b2b_first", 64'(dpos[0]), 64'(W));
    chk("b2b_gap1", 64'(dpos[1] - dpos[0]), 64'(W + 1));
    chk("b2b_gap2", 64'(dpos[2] - dpos[1]), 64'(W + 1));
    chk("b2b_overlap", 64'(both), 64'd0);
    @(posedge clk);
    #1;
    chk("b2b_idle", {62'd0, bus.busy, bus.done}, 64'd0);

    // Reset at cycle 10 of a run: outputs clear at once, no done appears.
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = 32'd1000;
    bus.y     = 32'd2000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_f", {32'd0, bus.f}, 64'd0);
    chk("abort_done", {63'd0, bus.done}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 45; n++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    run_op(32'd3, 32'd4, 1'b0, busy_n, lat, both);
    chk("post_rst_f", {32'd0, bus.f}, 64'd7);
    chk("post_rst_lat", 64'(lat), 64'(W));
    chk("post_rst_busylen", 64'(busy_n), 64'(W));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
